// File: rtl/sram_drv_pkg.sv
// sram_drv_pkg: shared FSM states, width derivations and virtual-cell to physical-address mapping for the SRAM drivers
package sram_drv_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int sel_w(input int dw);
        return dw / 8;
    endfunction
    function automatic logic [63:0] cell_base(input logic [63:0] vaddr, input int unsigned translen);
        return (vaddr >> 2) * 64'(translen);
    endfunction
endpackage

// File: rtl/sram_rr_arb.sv
// sram_rr_arb: combinational round-robin pick (req, ptr -> gnt index, any) favouring the first requester at or after ptr
module sram_rr_arb
    import sram_drv_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CW  = ch_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [CW-1:0]  gnt,
    output logic           any
);
    always_comb begin
        gnt = ptr;
        any = |req;
        for (int i = NCH - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % NCH]) gnt = CW'((int'(ptr) + i) % NCH);
    end
endmodule

// File: rtl/sram_block_arb_drv.sv
// sram_block_arb_drv: NCH write requesters -> SRAM port A, NCH read requesters -> port B, cell-granular round-robin, tagged read return
module sram_block_arb_drv
    import sram_drv_pkg::*;
#(
    parameter int DW       = 32,
    parameter int PAW      = 14,
    parameter int VAW      = 12,
    parameter int NCH      = 2,
    parameter int TRANSLEN = 16,
    parameter int RDLAT    = 1
) (
    input  logic                        iClk,
    input  logic                        iRst_n,
    input  logic [NCH-1:0]              iWrReq,
    input  logic [NCH-1:0]              iWrValid,
    input  logic [NCH-1:0]              iWrLast,
    input  logic [NCH*VAW-1:0]          iWrAddr,
    input  logic [NCH*sel_w(DW)-1:0]    iWrSel,
    input  logic [NCH*DW-1:0]           iWrData,
    output logic [NCH-1:0]              oWrReady,
    output logic                        oWrErr,
    input  logic [NCH-1:0]              iRdReq,
    input  logic [NCH-1:0]              iRdValid,
    input  logic [NCH-1:0]              iRdLast,
    input  logic [NCH*VAW-1:0]          iRdAddr,
    output logic [NCH-1:0]              oRdReady,
    output logic [DW-1:0]               oRdData,
    output logic                        oRdDataValid,
    output logic [ch_w(NCH)-1:0]        oRdDataCh,
    output logic                        oCEnA,
    output logic                        oWEnA,
    output logic [DW-1:0]               oBWEnA,
    output logic [PAW-1:0]              oAddrA,
    output logic [DW-1:0]               oWDataA,
    output logic                        oCEnB,
    output logic                        oWEnB,
    output logic [DW-1:0]               oBWEnB,
    output logic [PAW-1:0]              oAddrB,
    output logic [DW-1:0]               oWDataB,
    input  logic [DW-1:0]               iRDataA,
    input  logic [DW-1:0]               iRDataB
);
    localparam int SW = sel_w(DW);
    localparam int CW = ch_w(NCH);
    localparam int TW = $clog2(TRANSLEN);

    // direction 0 is the write path, direction 1 the read path
    logic [1:0][NCH-1:0]     req_d, vld_d, lst_d, rdy_d;
    logic [1:0][NCH*VAW-1:0] va_d;
    logic [1:0]              acc_d, end_d;
    logic [1:0][CW-1:0]      g_d;
    logic [1:0][PAW-1:0]     pa_d;
    logic [RDLAT-1:0]        vp;
    logic [RDLAT-1:0][CW-1:0] cp;
    logic                    unused_ok;

    assign req_d = {iRdReq, iWrReq};
    assign vld_d = {iRdValid, iWrValid};
    assign lst_d = {iRdLast, iWrLast};
    assign va_d  = {iRdAddr, iWrAddr};

    for (genvar d = 0; d < 2; d++) begin : g_dir
        state_t          st, st_nx;
        logic [CW-1:0]   ptr, gnt, arb_g;
        logic            any;
        logic [TW-1:0]   cnt;
        logic [PAW-1:0]  base;

        sram_rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
            .req (req_d[d]),
            .ptr (ptr),
            .gnt (arb_g),
            .any (any)
        );

        assign acc_d[d] = (st == BUSY) && vld_d[d][gnt];
        assign end_d[d] = acc_d[d] && (lst_d[d][gnt] || cnt == TW'(TRANSLEN - 1));
        assign rdy_d[d] = (st == BUSY) ? NCH'(1) << gnt : '0;
        assign pa_d[d]  = base + PAW'(cnt);
        assign g_d[d]   = gnt;

        always_comb begin
            st_nx = st;
            st_nx = (st == IDLE) ? (any ? BUSY : IDLE) : (end_d[d] ? IDLE : BUSY);
        end

        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                st   <= IDLE;
                ptr  <= '0;
                gnt  <= '0;
                cnt  <= '0;
                base <= '0;
            end else begin
                st <= st_nx;
                if (st == IDLE && any) begin
                    gnt  <= arb_g;
                    cnt  <= '0;
                    base <= PAW'(cell_base(64'(va_d[d][arb_g*VAW +: VAW]), TRANSLEN));
                end else if (end_d[d]) begin
                    cnt <= '0;
                    ptr <= (gnt == CW'(NCH - 1)) ? '0 : gnt + 1'b1;
                end else if (acc_d[d]) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign oWrReady = rdy_d[0];
    assign oRdReady = rdy_d[1];
    // the only way a write cell ends without Last is the beat limit
    assign oWrErr   = end_d[0] & ~lst_d[0][g_d[0]];

    assign oCEnA   = ~acc_d[0];
    assign oWEnA   = ~acc_d[0];
    assign oAddrA  = acc_d[0] ? pa_d[0] : '0;
    assign oWDataA = acc_d[0] ? iWrData[g_d[0]*DW +: DW] : '0;

    always_comb begin
        oBWEnA = '1;
        for (int i = 0; i < SW; i++)
            oBWEnA[i*8 +: 8] = ~{8{acc_d[0] & iWrSel[g_d[0]*SW + i]}};
    end

    assign oCEnB   = ~acc_d[1];
    assign oWEnB   = 1'b1;
    assign oBWEnB  = '1;
    assign oAddrB  = acc_d[1] ? pa_d[1] : '0;
    assign oWDataB = '0;
    assign oRdData = iRDataB;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            vp <= '0;
            cp <= '0;
        end else begin
            vp[0] <= acc_d[1];
            cp[0] <= acc_d[1] ? g_d[1] : '0;
            for (int i = 1; i < RDLAT; i++) begin
                vp[i] <= vp[i-1];
                cp[i] <= cp[i-1];
            end
        end
    end

    assign oRdDataValid = vp[RDLAT-1];
    assign oRdDataCh    = cp[RDLAT-1];
    assign unused_ok    = ^iRDataA;
endmodule

// File: tb/tb_sram_block_arb_drv.sv
// tb_sram_block_arb_drv: directed table-driven and sequence checks of the SRAM arbiter/driver
module tb_sram_block_arb_drv;
    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic [1:0]  iWrReq, iWrValid, iWrLast, oWrReady;
    logic [23:0] iWrAddr;
    logic [7:0]  iWrSel;
    logic [63:0] iWrData;
    logic        oWrErr;
    logic [1:0]  iRdReq, iRdValid, iRdLast, oRdReady;
    logic [23:0] iRdAddr;
    logic [31:0] oRdData, oBWEnA, oWDataA, oBWEnB, oWDataB, iRDataA, iRDataB;
    logic        oRdDataValid, oRdDataCh;
    logic        oCEnA, oWEnA, oCEnB, oWEnB;
    logic [13:0] oAddrA, oAddrB;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [1:0]  req, vld, lst;
        logic [3:0]  sel;
        logic [31:0] d;
        logic [1:0]  rdy;
        logic        en;
        logic [13:0] addr;
        logic [31:0] bwen, wd;
        logic        err;
    } wvec_t;
    wvec_t tbl[$];

    sram_block_arb_drv #(.RDLAT(2)) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iWrReq(iWrReq), .iWrValid(iWrValid), .iWrLast(iWrLast), .iWrAddr(iWrAddr),
        .iWrSel(iWrSel), .iWrData(iWrData), .oWrReady(oWrReady), .oWrErr(oWrErr),
        .iRdReq(iRdReq), .iRdValid(iRdValid), .iRdLast(iRdLast), .iRdAddr(iRdAddr),
        .oRdReady(oRdReady), .oRdData(oRdData), .oRdDataValid(oRdDataValid), .oRdDataCh(oRdDataCh),
        .oCEnA(oCEnA), .oWEnA(oWEnA), .oBWEnA(oBWEnA), .oAddrA(oAddrA), .oWDataA(oWDataA),
        .oCEnB(oCEnB), .oWEnB(oWEnB), .oBWEnB(oBWEnB), .oAddrB(oAddrB), .oWDataB(oWDataB),
        .iRDataA(iRDataA), .iRDataB(iRDataB)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    function automatic wvec_t v(input logic [1:0] req, vld, lst, input logic [3:0] sel, input logic [31:0] d,
                                input logic [1:0] rdy, input logic en, input logic [13:0] addr,
                                input logic [31:0] bwen, wd, input logic err);
        wvec_t r;
        r.req = req; r.vld = vld; r.lst = lst; r.sel = sel; r.d = d;
        r.rdy = rdy; r.en = en; r.addr = addr; r.bwen = bwen; r.wd = wd; r.err = err;
        return r;
    endfunction

    function automatic wvec_t idle(input logic [1:0] req);
        return v(req, 2'b00, 2'b00, 4'hF, 32'h0, 2'b00, 1'b1, 14'd0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_wrdy"}, oWrReady, 2'b00);
        chk({tag, "_rrdy"}, oRdReady, 2'b00);
        chk({tag, "_err"}, oWrErr, 1'b0);
        chk({tag, "_rvalid"}, oRdDataValid, 1'b0);
        chk({tag, "_rch"}, oRdDataCh, 1'b0);
        chk({tag, "_enables"}, {oCEnA, oWEnA, oCEnB, oWEnB}, 4'hF);
        chk({tag, "_bwena"}, oBWEnA, 32'hFFFF_FFFF);
        chk({tag, "_addra"}, oAddrA, 14'd0);
        chk({tag, "_addrb"}, oAddrB, 14'd0);
        chk({tag, "_wdataa"}, oWDataA, 32'h0);
    endtask

    initial begin
        iWrReq = 0; iWrValid = 0; iWrLast = 0; iWrSel = 0; iWrData = 0;
        iRdReq = 0; iRdValid = 0; iRdLast = 0; iRDataA = 0; iRDataB = 0;
        iWrAddr = {12'h00C, 12'h008};
        iRdAddr = {12'h004, 12'h000};

        tbl.push_back(idle(2'b01));
        for (int k = 0; k < 16; k++)
            tbl.push_back(v(2'b01, 2'b01, (k == 15) ? 2'b01 : 2'b00, 4'hF, 32'(k),
                            2'b01, 1'b0, 14'(32 + k), 32'h0, 32'(k), 1'b0));
        tbl.push_back(idle(2'b00));
        tbl.push_back(idle(2'b10));
        tbl.push_back(v(2'b10, 2'b10, 2'b10, 4'b0101, 32'hA5A5_5A5A, 2'b10, 1'b0, 14'd48, 32'hFF00_FF00, 32'hA5A5_5A5A, 1'b0));
        tbl.push_back(idle(2'b11));
        tbl.push_back(v(2'b11, 2'b11, 2'b00, 4'hF, 32'd1, 2'b01, 1'b0, 14'd32, 32'h0, 32'd1, 1'b0));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 4'hF, 32'd0, 2'b01, 1'b1, 14'd0, 32'hFFFF_FFFF, 32'h0, 1'b0));
        tbl.push_back(v(2'b11, 2'b11, 2'b01, 4'hF, 32'd2, 2'b01, 1'b0, 14'd33, 32'h0, 32'd2, 1'b0));
        tbl.push_back(idle(2'b11));
        tbl.push_back(v(2'b11, 2'b11, 2'b10, 4'hF, 32'd3, 2'b10, 1'b0, 14'd48, 32'h0, 32'd3, 1'b0));
        tbl.push_back(idle(2'b00));

        tick;
        tick;
        chk_reset_outs("por");
        iRst_n = 1'b1;

        foreach (tbl[i]) begin
            iWrReq = tbl[i].req; iWrValid = tbl[i].vld; iWrLast = tbl[i].lst;
            iWrSel = {tbl[i].sel, tbl[i].sel}; iWrData = {tbl[i].d, tbl[i].d};
            @(negedge iClk);
            chk($sformatf("row%0d_rdy", i), oWrReady, tbl[i].rdy);
            chk($sformatf("row%0d_en", i), {oCEnA, oWEnA}, {tbl[i].en, tbl[i].en});
            chk($sformatf("row%0d_addr", i), oAddrA, tbl[i].addr);
            chk($sformatf("row%0d_bwen", i), oBWEnA, tbl[i].bwen);
            chk($sformatf("row%0d_wdata", i), oWDataA, tbl[i].wd);
            chk($sformatf("row%0d_err", i), oWrErr, tbl[i].err);
            tick;
        end

        // forced termination at the beat limit
        iWrReq = 2'b01; iWrValid = 2'b00; iWrLast = 2'b00; iWrSel = 8'hFF;
        tick;
        for (int k = 0; k < 16; k++) begin
            iWrValid = 2'b01; iWrData = {32'h0, 32'(100 + k)};
            @(negedge iClk);
            chk($sformatf("force_b%0d_err", k), oWrErr, k == 15);
            chk($sformatf("force_b%0d_addr", k), oAddrA, 14'(32 + k));
            tick;
        end
        @(negedge iClk);
        chk("force_wait_rdy", oWrReady, 2'b00);
        chk("force_wait_cen", oCEnA, 1'b1);
        chk("force_wait_err", oWrErr, 1'b0);
        tick;
        iWrLast = 2'b01;
        @(negedge iClk);
        chk("force_regrant_rdy", oWrReady, 2'b01);
        chk("force_regrant_addr", oAddrA, 14'd32);
        tick;
        iWrReq = 0; iWrValid = 0; iWrLast = 0;
        tick;

        // read channel 1, 4 beats, RDLAT = 2
        for (int t = 0; t < 8; t++) begin
            iRdReq   = (t <= 4) ? 2'b10 : 2'b00;
            iRdValid = (t >= 1 && t <= 4) ? 2'b10 : 2'b00;
            iRdLast  = (t == 4) ? 2'b10 : 2'b00;
            iRDataB  = 32'hC0DE_0000 + 32'(t);
            @(negedge iClk);
            if (t >= 1 && t <= 4) begin
                chk($sformatf("rd_t%0d_cenb", t), oCEnB, 1'b0);
                chk($sformatf("rd_t%0d_addrb", t), oAddrB, 14'(16 + t - 1));
                chk($sformatf("rd_t%0d_rdy", t), oRdReady, 2'b10);
            end else begin
                chk($sformatf("rd_t%0d_cenb", t), oCEnB, 1'b1);
                chk($sformatf("rd_t%0d_rdy", t), oRdReady, 2'b00);
            end
            chk($sformatf("rd_t%0d_valid", t), oRdDataValid, t >= 3 && t <= 6);
            chk($sformatf("rd_t%0d_ch", t), oRdDataCh, t >= 3 && t <= 6);
            chk($sformatf("rd_t%0d_data", t), oRdData, 32'hC0DE_0000 + 32'(t));
            tick;
        end

        // reset in the middle of a write cell at beat 7
        iWrReq = 2'b01; iWrValid = 2'b00; iWrSel = 8'hFF; iWrData = {32'h0, 32'h1234_5678};
        tick;
        iWrValid = 2'b01;
        for (int k = 0; k < 7; k++) tick;
        chk("mid_beat7_addr", oAddrA, 14'd39);
        #1;
        iRst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        @(negedge iClk);
        #1;
        iRst_n = 1'b1;
        #1;
        chk("post_rst_idle_rdy", oWrReady, 2'b00);
        tick;
        @(negedge iClk);
        chk("post_rst_rdy", oWrReady, 2'b01);
        chk("post_rst_addr", oAddrA, 14'd32);
        chk("post_rst_cen", oCEnA, 1'b0);
        iWrLast = 2'b01;
        tick;
        iWrReq = 0; iWrValid = 0; iWrLast = 0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
